// File: rtl/onehot_pkg.sv
// onehot_pkg: shared types and helpers for the one-hot checker.
//   state_t : checker FSM states (IDLE, RUN, FAULT).
//   idx_w() : width of the encoded index for a given select-bus width.
package onehot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  function automatic int unsigned idx_w(input int unsigned width);
    // Widths below 2 are illegal; keep the index at least one bit wide anyway.
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// onehot_encoder: purely combinational classifier for a select bus.
// Build option: ONEHOT_PRIORITY_EN -- when defined, index reports the lowest
// set bit for any non-zero input (including multi-hot); when undefined, index
// is non-zero only for a true one-hot input.
// Ports:
//   S     in  WIDTH  select bus
//   zero  out 1      S == 0
//   valid out 1      exactly one bit of S set
//   index out IW     encoded bit position
module onehot_encoder
  import onehot_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IW    = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] S,
  output logic             zero,
  output logic             valid,
  output logic [IW-1:0]    index
);

  logic [IW-1:0] lowest;

  // Scan from the top so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    lowest = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (S[i]) lowest = IW'(i);
    end
  end

  always_comb begin
    zero  = (S == '0);
    // Clearing the lowest set bit leaves nothing behind only for a single bit.
    valid = !zero && ((S & (S - WIDTH'(1))) == '0);
`ifdef ONEHOT_PRIORITY_EN
    index = lowest;
`else
    index = valid ? lowest : '0;
`endif
  end

endmodule

// File: rtl/onehot_checker.sv
// onehot_checker: registered runtime checker for one-hot select buses.
// Classifies each in_valid sample (one cycle latency), counts violations
// (zero or multi-hot) in a saturating counter and latches FAULT once
// ERR_LIMIT violations have been seen. Index encoding depends on the
// ONEHOT_PRIORITY_EN build option (see onehot_encoder).
// Ports:
//   clk       in  1      rising-edge clock
//   rst_n     in  1      asynchronous active-low reset
//   in_valid  in  1      S is sampled this cycle
//   S         in  WIDTH  select bus under check
//   clear     in  1      synchronous clear of counter and FAULT
//   out_valid out 1      registered result valid
//   Zero      out 1      sampled S == 0
//   Valid     out 1      sampled S one-hot
//   Index     out IW     encoded bit position
//   ErrCount  out CNT_W  saturating violation count
//   Fault     out 1      FSM is in FAULT
module onehot_checker
  import onehot_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned ERR_LIMIT = 3,
  parameter int unsigned IW        = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] S,
  input  logic             clear,
  output logic             out_valid,
  output logic             Zero,
  output logic             Valid,
  output logic [IW-1:0]    Index,
  output logic [CNT_W-1:0] ErrCount,
  output logic             Fault
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] ErrLim = CNT_W'(ERR_LIMIT);

  logic          enc_zero;
  logic          enc_valid;
  logic [IW-1:0] enc_index;

  onehot_encoder #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_enc (
    .S     (S),
    .zero  (enc_zero),
    .valid (enc_valid),
    .index (enc_index)
  );

  logic             out_valid_q;
  logic             zero_q, valid_q;
  logic [IW-1:0]    index_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  state_t           state_q, state_d;
  logic             viol;

  assign viol = in_valid && !enc_valid;

  always_comb begin
    cnt_inc = (viol && (cnt_q != CntMax)) ? cnt_q + CNT_W'(1) : cnt_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (clear) begin
      // Clear takes priority; a simultaneous violation is dropped.
      cnt_d   = '0;
      state_d = IDLE;
    end else if (in_valid) begin
      cnt_d = cnt_inc;
      unique case (state_q)
        IDLE:    state_d = (cnt_inc >= ErrLim) ? FAULT : RUN;
        RUN:     state_d = (cnt_inc >= ErrLim) ? FAULT : RUN;
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      valid_q     <= 1'b0;
      index_q     <= '0;
      cnt_q       <= '0;
      state_q     <= IDLE;
    end else begin
      out_valid_q <= in_valid;
      // The result of a sample is reported even when clear is asserted.
      if (in_valid) begin
        zero_q  <= enc_zero;
        valid_q <= enc_valid;
        index_q <= enc_index;
      end
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Zero      = zero_q;
  assign Valid     = valid_q;
  assign Index     = index_q;
  assign ErrCount  = cnt_q;
  assign Fault     = (state_q == FAULT);

endmodule

// File: tb/tb_onehot_checker.sv
// Directed bench for onehot_checker (WIDTH=4, CNT_W=8, ERR_LIMIT=3).
module tb_onehot_checker;
  import onehot_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] S;
  logic       clear;
  logic       out_valid;
  logic       Zero;
  logic       Valid;
  logic [1:0] Index;
  logic [7:0] ErrCount;
  logic       Fault;

  int unsigned n_total;
  int unsigned n_pass;

  onehot_checker #(
    .WIDTH     (4),
    .CNT_W     (8),
    .ERR_LIMIT (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .S         (S),
    .clear     (clear),
    .out_valid (out_valid),
    .Zero      (Zero),
    .Valid     (Valid),
    .Index     (Index),
    .ErrCount  (ErrCount),
    .Fault     (Fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic step(input logic v, input logic [3:0] s, input logic c);
    in_valid = v;
    S        = s;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expectations for the 0..15 sweep starting from IDLE.
  logic [15:0] exp_valid_t = 16'b0000_0001_0001_0110;
  int unsigned exp_cnt_t[16] = '{1, 1, 1, 2, 2, 3, 4, 5, 5, 6, 7, 8, 9, 10, 11, 12};
`ifdef ONEHOT_PRIORITY_EN
  int unsigned exp_idx_t[16] = '{0, 0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0};
  localparam int unsigned ExpIdx6 = 1;
`else
  int unsigned exp_idx_t[16] = '{0, 0, 1, 0, 2, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0};
  localparam int unsigned ExpIdx6 = 0;
`endif

  initial begin
    n_total  = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    S        = 4'd0;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_zero", 64'(Zero), 64'd0);
    check("rst_valid", 64'(Valid), 64'd0);
    check("rst_index", 64'(Index), 64'd0);
    check("rst_errcount", 64'(ErrCount), 64'd0);
    check("rst_fault", 64'(Fault), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: sweep S = 0..15; third violation is S=5, Fault rises there.
    for (int s = 0; s < 16; s++) begin
      step(1'b1, 4'(s), 1'b0);
      check($sformatf("sweep%0d_out_valid", s), 64'(out_valid), 64'd1);
      check($sformatf("sweep%0d_zero", s), 64'(Zero), (s == 0) ? 64'd1 : 64'd0);
      check($sformatf("sweep%0d_valid", s), 64'(Valid), 64'(exp_valid_t[s]));
      check($sformatf("sweep%0d_index", s), 64'(Index), 64'(exp_idx_t[s]));
      check($sformatf("sweep%0d_errcount", s), 64'(ErrCount), 64'(exp_cnt_t[s]));
      check($sformatf("sweep%0d_fault", s), 64'(Fault), (s >= 5) ? 64'd1 : 64'd0);
    end

    // 2: multi-hot 4'b0110.
    step(1'b1, 4'b0110, 1'b0);
    check("mh6_valid", 64'(Valid), 64'd0);
    check("mh6_zero", 64'(Zero), 64'd0);
    check("mh6_index", 64'(Index), 64'(ExpIdx6));
    check("mh6_errcount", 64'(ErrCount), 64'd13);

    // 3: clear, 260 violations (saturate), clear again.
    step(1'b0, 4'd0, 1'b1);
    check("clr0_errcount", 64'(ErrCount), 64'd0);
    check("clr0_fault", 64'(Fault), 64'd0);
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 4'b0011, 1'b0);
      if (i == 1) check("sat_pre_fault", 64'(Fault), 64'd0);
      if (i == 2) check("sat_fault_rise", 64'(Fault), 64'd1);
      if (i == 254) check("sat_reach255", 64'(ErrCount), 64'd255);
    end
    check("sat_hold255", 64'(ErrCount), 64'd255);
    check("sat_fault", 64'(Fault), 64'd1);
    step(1'b0, 4'd0, 1'b1);
    check("clr1_errcount", 64'(ErrCount), 64'd0);
    check("clr1_fault", 64'(Fault), 64'd0);
    check("clr1_state", 64'(dut.state_q), 64'(IDLE));
    check("clr1_out_valid", 64'(out_valid), 64'd0);

    // 4: two violations, then clear together with a violating sample.
    step(1'b1, 4'd0, 1'b0);
    step(1'b1, 4'd0, 1'b0);
    check("pre4_errcount", 64'(ErrCount), 64'd2);
    step(1'b1, 4'd3, 1'b1);
    check("clrv_out_valid", 64'(out_valid), 64'd1);
    check("clrv_valid", 64'(Valid), 64'd0);
    check("clrv_zero", 64'(Zero), 64'd0);
    check("clrv_errcount", 64'(ErrCount), 64'd0);
    check("clrv_fault", 64'(Fault), 64'd0);
    step(1'b1, 4'd9, 1'b0);
    check("post4_errcount", 64'(ErrCount), 64'd1);
    check("post4_fault", 64'(Fault), 64'd0);

    // 5: one-hot sample, then 5 idle cycles with S toggling.
    step(1'b1, 4'd4, 1'b0);
    check("hold_ref_valid", 64'(Valid), 64'd1);
    check("hold_ref_index", 64'(Index), 64'd2);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, (i % 2 == 0) ? 4'b1111 : 4'b0000, 1'b0);
      check($sformatf("hold%0d_out_valid", i), 64'(out_valid), 64'd0);
      check($sformatf("hold%0d_zero", i), 64'(Zero), 64'd0);
      check($sformatf("hold%0d_valid", i), 64'(Valid), 64'd1);
      check($sformatf("hold%0d_index", i), 64'(Index), 64'd2);
      check($sformatf("hold%0d_errcount", i), 64'(ErrCount), 64'd1);
    end

    // 6: two violations, asynchronous reset mid-cycle, then one violation.
    step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'd0, 1'b0);
    check("pre6_errcount", 64'(ErrCount), 64'd3);
    check("pre6_fault", 64'(Fault), 64'd1);
    check("pre6_zero", 64'(Zero), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_zero", 64'(Zero), 64'd0);
    check("arst_valid", 64'(Valid), 64'd0);
    check("arst_index", 64'(Index), 64'd0);
    check("arst_errcount", 64'(ErrCount), 64'd0);
    check("arst_fault", 64'(Fault), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'd6, 1'b0);
    check("post6_out_valid", 64'(out_valid), 64'd1);
    check("post6_errcount", 64'(ErrCount), 64'd1);
    check("post6_fault", 64'(Fault), 64'd0);
    step(1'b0, 4'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
